conv_if_window_gen: RTL and testbench



---
 rtl/conv_if_window_gen.sv | 227 ++++++++++++++++++++++
 tb/tb_conv_if_window_gen.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_if_window_gen.sv
// Input-feature window generator: raster-scans one frame from SRAM and emits one zero-padded
// 3x3xIF_CHANNEL window per pixel. Build option IFWIN_ZERO_INVALID_EN zeroes if_o_data while invalid.
module conv_if_window_gen #(
    parameter int IF_WIDTH    = 128,
    parameter int IF_HEIGHT   = 128,
    parameter int IF_CHANNEL  = 3,
    parameter int IF_BITWIDTH = 16,
    parameter int IF_PORT     = 27,
    parameter int ADDR_W      = $clog2(IF_WIDTH*IF_HEIGHT)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              if_start,
    output logic                              busy,
    output logic                              done,
    output logic                              mem_rd_en,
    output logic [ADDR_W-1:0]                 mem_rd_addr,
    input  logic [IF_CHANNEL*IF_BITWIDTH-1:0] mem_rd_data,
    output logic [IF_PORT*IF_BITWIDTH-1:0]    if_o_data,
    output logic [IF_PORT-1:0]                if_o_valid
);

    localparam int PIX_W = IF_CHANNEL * IF_BITWIDTH;
    localparam int RW    = $clog2(IF_HEIGHT + 1);
    localparam int CW    = $clog2(IF_WIDTH + 1);
    localparam logic [RW-1:0] LAST_R = RW'(IF_HEIGHT);
    localparam logic [CW-1:0] LAST_C = CW'(IF_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic                drain_q;
    logic [RW-1:0]       sr_q;
    logic [CW-1:0]       sc_q;
    logic                busy_q;
    logic                done_q;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_q;

    logic [RW-1:0]       nsr_d;
    logic [CW-1:0]       nsc_d;
    logic                last_step_s;
    logic                nrd_s;

    logic                st2_vld_q;
    logic                st2_rd_q;
    logic [RW-1:0]       st2_sr_q;
    logic [CW-1:0]       st2_sc_q;

    logic [PIX_W-1:0]    lb1_q [IF_WIDTH+1];
    logic [PIX_W-1:0]    lb2_q [IF_WIDTH+1];
    logic [PIX_W-1:0]    sh0_q [3];
    logic [PIX_W-1:0]    sh1_q [3];
    logic [PIX_W-1:0]    col_s [3];
    logic                in_col_s;
    logic [IF_PORT*IF_BITWIDTH-1:0] win_s;
    logic                emit_s;

    logic                          vld_q;
    logic [IF_PORT*IF_BITWIDTH-1:0] dat_q;

    // Next raster position and whether that step reads a real pixel
    always_comb begin
        nsr_d = sr_q;
        nsc_d = sc_q + CW'(1);
        if (sc_q == LAST_C) begin
            nsr_d = sr_q + RW'(1);
            nsc_d = '0;
        end else begin
            nsr_d = sr_q;
        end
        last_step_s = (sr_q == LAST_R) && (sc_q == LAST_C);
        nrd_s       = (nsr_d < LAST_R) && (nsc_d < LAST_C);
    end

    // Frame control FSM, scan counters and SRAM read port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            drain_q   <= 1'b0;
            sr_q      <= '0;
            sc_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (if_start) begin
                        state_q   <= ST_SCAN;
                        busy_q    <= 1'b1;
                        sr_q      <= '0;
                        sc_q      <= '0;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end
                end
                ST_SCAN: begin
                    if (last_step_s) begin
                        state_q <= ST_DRAIN;
                        drain_q <= 1'b0;
                        rd_en_q <= 1'b0;
                    end else begin
                        sr_q    <= nsr_d;
                        sc_q    <= nsc_d;
                        rd_en_q <= nrd_s;
                        // Reads are contiguous in raster order, so the address just counts up
                        if (nrd_s) begin
                            rd_addr_q <= rd_addr_q + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Step descriptor aligned with the cycle in which read data arrives
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st2_vld_q <= 1'b0;
            st2_rd_q  <= 1'b0;
            st2_sr_q  <= '0;
            st2_sc_q  <= '0;
        end else begin
            st2_vld_q <= (state_q == ST_SCAN);
            st2_rd_q  <= rd_en_q;
            st2_sr_q  <= sr_q;
            st2_sc_q  <= sc_q;
        end
    end

    // Newest window column: rows sr-2, sr-1, sr at column sc, zero outside the frame
    always_comb begin
        in_col_s = (st2_sc_q != LAST_C);
        col_s[0] = (in_col_s && (st2_sr_q >= RW'(2))) ? lb2_q[st2_sc_q] : '0;
        col_s[1] = (in_col_s && (st2_sr_q >= RW'(1))) ? lb1_q[st2_sc_q] : '0;
        col_s[2] = st2_rd_q ? mem_rd_data : '0;
        emit_s   = st2_vld_q && (st2_sr_q != '0) && (st2_sc_q != '0);
    end

    // Assemble window: port = c*9 + ky*3 + kx
    always_comb begin
        win_s = '0;
        for (int c = 0; c < IF_CHANNEL; c++) begin
            for (int ky = 0; ky < 3; ky++) begin
                win_s[(c*9 + ky*3 + 0)*IF_BITWIDTH +: IF_BITWIDTH] = sh0_q[ky][c*IF_BITWIDTH +: IF_BITWIDTH];
                win_s[(c*9 + ky*3 + 1)*IF_BITWIDTH +: IF_BITWIDTH] = sh1_q[ky][c*IF_BITWIDTH +: IF_BITWIDTH];
                win_s[(c*9 + ky*3 + 2)*IF_BITWIDTH +: IF_BITWIDTH] = col_s[ky][c*IF_BITWIDTH +: IF_BITWIDTH];
            end
        end
    end

    // Line buffers and the two older window columns
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= IF_WIDTH; i++) begin
                lb1_q[i] <= '0;
                lb2_q[i] <= '0;
            end
            for (int k = 0; k < 3; k++) begin
                sh0_q[k] <= '0;
                sh1_q[k] <= '0;
            end
        end else if (st2_vld_q) begin
            lb1_q[st2_sc_q] <= col_s[2];
            lb2_q[st2_sc_q] <= lb1_q[st2_sc_q];
            for (int k = 0; k < 3; k++) begin
                // Column -1 of a new row is forced to zero so no previous-row data leaks in
                sh0_q[k] <= (st2_sc_q == '0) ? '0 : sh1_q[k];
                sh1_q[k] <= col_s[k];
            end
        end
    end

    // Registered window output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= emit_s;
            if (emit_s) begin
                dat_q <= win_s;
            end else begin
`ifdef IFWIN_ZERO_INVALID_EN
                dat_q <= '0;
`else
                dat_q <= dat_q;
`endif
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign if_o_valid  = {IF_PORT{vld_q}};
    assign if_o_data   = dat_q;

endmodule

// File: tb/tb_conv_if_window_gen.sv
// Self-checking bench for conv_if_window_gen on a 4x4x3 frame against a window-level reference model.
module tb_conv_if_window_gen;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int REC  = 48;
    localparam int DW   = 27 * 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_start;
    logic            busy;
    logic            done;
    logic            mem_rd_en;
    logic [3:0]      mem_rd_addr;
    logic [47:0]     mem_rd_data;
    logic [DW-1:0]   if_o_data;
    logic [26:0]     if_o_valid;

    logic [47:0]     mem [16];

    int n_tests = 0;
    int n_fail  = 0;

    bit            rec_vld  [REC];
    bit            rec_vbad [REC];
    bit            rec_done [REC];
    bit            rec_busy [REC];
    bit            rec_rd   [REC];
    logic [3:0]    rec_addr [REC];
    logic [DW-1:0] rec_dat  [REC];

    int n_vld, n_done, done_rel, busy_first, busy_last, busy_n;
    int rd_n, rd_first, rd_bad, vbad_n;
    int vidx [16];
    logic [DW-1:0] saved [16];

    conv_if_window_gen #(
        .IF_WIDTH(W), .IF_HEIGHT(H), .IF_CHANNEL(3), .IF_BITWIDTH(16), .IF_PORT(27), .ADDR_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .if_start(if_start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .if_o_data(if_o_data), .if_o_valid(if_o_valid)
    );

    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency, garbage when not reading
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        else           mem_rd_data <= {16'($urandom), 16'($urandom), 16'($urandom)};
    end

    function automatic logic [DW-1:0] exp_win(input int oy, input int ox);
        logic [DW-1:0] w;
        w = '0;
        for (int p = 0; p < 27; p++) begin
            int c  = p / 9;
            int ky = (p % 9) / 3;
            int kx = p % 3;
            int y  = oy + ky - 1;
            int x  = ox + kx - 1;
            logic [47:0] px;
            if (y >= 0 && y < H && x >= 0 && x < W) begin
                px = mem[y*W + x];
                w[p*16 +: 16] = px[c*16 +: 16];
            end
        end
        return w;
    endfunction

    function automatic logic [15:0] port_of(input logic [DW-1:0] v, input int p);
        return v[p*16 +: 16];
    endfunction

    task automatic fill_pattern();
        for (int a = 0; a < 16; a++)
            for (int c = 0; c < 3; c++)
                mem[a][c*16 +: 16] = 16'((c << 12) | a);
    endtask

    task automatic fill_random();
        for (int a = 0; a < 16; a++)
            mem[a] = {16'($urandom), 16'($urandom), 16'($urandom)};
    endtask

    // Pulse if_start, then record REC-1 cycles; rel cycle 1 is the first cycle after the sampling edge
    task automatic run_frame(input int scan_pulse, input bit done_pulse, input int rst_at);
        @(negedge clk); if_start = 1'b1;
        @(negedge clk); if_start = 1'b0;
        for (int r = 1; r < REC; r++) begin
            if (r > 1) @(negedge clk);
            rec_vld[r]  = if_o_valid[0];
            rec_vbad[r] = (if_o_valid !== {27{if_o_valid[0]}});
            rec_done[r] = (done === 1'b1);
            rec_busy[r] = (busy === 1'b1);
            rec_rd[r]   = (mem_rd_en === 1'b1);
            rec_addr[r] = mem_rd_addr;
            rec_dat[r]  = if_o_data;
            if_start = (r == scan_pulse) || (done_pulse && done === 1'b1);
            rst_n    = (r == rst_at) ? 1'b0 : 1'b1;
        end
        if_start = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic analyze();
        n_vld = 0; n_done = 0; done_rel = -1; busy_first = -1; busy_last = -1; busy_n = 0;
        rd_n = 0; rd_first = -1; rd_bad = 0; vbad_n = 0;
        for (int r = 1; r < REC; r++) begin
            if (rec_vld[r]) begin
                if (n_vld < 16) vidx[n_vld] = r;
                n_vld++;
            end
            if (rec_done[r]) begin n_done++; done_rel = r; end
            if (rec_busy[r]) begin
                if (busy_first < 0) busy_first = r;
                busy_last = r; busy_n++;
            end
            if (rec_rd[r]) begin
                if (rd_first < 0) rd_first = r;
                if (int'(rec_addr[r]) != rd_n) rd_bad++;
                rd_n++;
            end
            if (rec_vbad[r]) vbad_n++;
        end
    endtask

    task automatic check_frame(input string tag);
        int terr;
        n_tests++;
        if (rd_first != 1) begin n_fail++; $display("FAIL %s first_read_cycle got %0d want 1", tag, rd_first); end
        n_tests++;
        if (rd_n != 16 || rd_bad != 0) begin
            n_fail++; $display("FAIL %s read_seq got %0d reads (%0d out of order) want 16 in order", tag, rd_n, rd_bad);
        end
        n_tests++;
        if (n_vld != 16) begin n_fail++; $display("FAIL %s valid_count got %0d want 16", tag, n_vld); end
        n_tests++;
        if (n_vld > 0 && vidx[0] != 9) begin n_fail++; $display("FAIL %s first_valid_cycle got %0d want 9", tag, vidx[0]); end
        terr = 0;
        for (int i = 0; i < 16; i++) begin
            int oy = i / W;
            int ox = i % W;
            if (i < n_vld && vidx[i] != 3 + (oy + 1)*(W + 1) + ox + 1) terr++;
            n_tests++;
            if (i >= n_vld || rec_dat[vidx[i]] !== exp_win(oy, ox)) begin
                n_fail++;
                $display("FAIL %s window(%0d,%0d) got %h want %h", tag, oy, ox,
                         (i < n_vld) ? rec_dat[vidx[i]] : '0, exp_win(oy, ox));
            end
        end
        n_tests++;
        if (terr != 0) begin n_fail++; $display("FAIL %s window_timing got %0d misplaced want 0", tag, terr); end
        n_tests++;
        if (n_done != 1 || done_rel != 28) begin
            n_fail++; $display("FAIL %s done got %0d pulses last at %0d want 1 at 28", tag, n_done, done_rel);
        end
        n_tests++;
        if (busy_first != 1 || busy_last != 28 || busy_n != 28) begin
            n_fail++; $display("FAIL %s busy got %0d..%0d (%0d cycles) want 1..28", tag, busy_first, busy_last, busy_n);
        end
        n_tests++;
        if (vbad_n != 0) begin n_fail++; $display("FAIL %s valid_bits_unequal got %0d cycles want 0", tag, vbad_n); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({busy, done, mem_rd_en} !== 3'b000 || mem_rd_addr !== 4'd0) begin
            n_fail++; $display("FAIL reset_ctrl got busy=%b done=%b rd_en=%b addr=%0d want 0", busy, done, mem_rd_en, mem_rd_addr);
        end
        n_tests++;
        if (if_o_valid !== 27'd0 || if_o_data !== '0) begin
            n_fail++; $display("FAIL reset_out got valid=%h data=%h want 0", if_o_valid, if_o_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic [DW-1:0] w0;
        fill_pattern();
        run_frame(0, 1'b0, 0);
        analyze();
        check_frame("basic");
        w0 = rec_dat[vidx[0]];
        n_tests++;
        if (port_of(w0, 0) !== 16'h0 || port_of(w0, 1) !== 16'h0 || port_of(w0, 2) !== 16'h0 ||
            port_of(w0, 3) !== 16'h0 || port_of(w0, 4) !== 16'h0000 || port_of(w0, 5) !== 16'h0001 ||
            port_of(w0, 7) !== 16'h0004 || port_of(w0, 8) !== 16'h0005 ||
            port_of(w0, 13) !== 16'h1000 || port_of(w0, 22) !== 16'h2000) begin
            n_fail++; $display("FAIL first_window_ports got %h want p5=0001 p7=0004 p8=0005 p13=1000 p22=2000", w0);
        end
    endtask

    task automatic test_corner();
        logic [DW-1:0] wl;
        wl = rec_dat[vidx[15]];
        n_tests++;
        if (port_of(wl, 0) !== 16'h000A || port_of(wl, 4) !== 16'h000F || port_of(wl, 5) !== 16'h0 ||
            port_of(wl, 6) !== 16'h0 || port_of(wl, 7) !== 16'h0 || port_of(wl, 8) !== 16'h0 ||
            port_of(wl, 22) !== 16'h200F) begin
            n_fail++; $display("FAIL corner_window got %h want p0=000A p4=000F p5..8=0 p22=200F", wl);
        end
    endtask

    task automatic test_left_edge();
        logic [DW-1:0] we;
        int bad;
        we  = rec_dat[vidx[4]];
        bad = 0;
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < 3; k++)
                if (port_of(we, c*9 + k*3) !== 16'h0) bad++;
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL left_edge_pad got %0d nonzero left ports in %h want 0", bad, we); end
    endtask

    task automatic test_invalid_data();
        logic [DW-1:0] want;
`ifdef IFWIN_ZERO_INVALID_EN
        int bad;
        want = '0;
        bad  = 0;
        for (int r = 1; r < REC; r++)
            if (!rec_vld[r] && rec_dat[r] !== '0) bad++;
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL invalid_zero got %0d nonzero invalid cycles want 0", bad); end
`else
        want = exp_win(0, 3);
`endif
        n_tests++;
        if (rec_vld[13] || rec_dat[13] !== want) begin
            n_fail++; $display("FAIL invalid_after_0_3 got vld=%b %h want vld=0 %h", rec_vld[13], rec_dat[13], want);
        end
    endtask

    task automatic test_start_filter();
        fill_random();
        run_frame(5, 1'b1, 0);
        analyze();
        check_frame("start_filter");
    endtask

    task automatic test_reset_mid_frame();
        int late;
        fill_pattern();
        run_frame(0, 1'b0, 11);
        analyze();
        n_tests++;
        if (rec_busy[12] || rec_done[12] || rec_rd[12] || rec_addr[12] !== 4'd0 || rec_vld[12] || rec_dat[12] !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got busy=%b done=%b rd=%b addr=%0d vld=%b data=%h want all 0",
                     rec_busy[12], rec_done[12], rec_rd[12], rec_addr[12], rec_vld[12], rec_dat[12]);
        end
        late = 0;
        for (int r = 12; r < REC; r++)
            if (rec_vld[r] || rec_busy[r] || rec_rd[r]) late++;
        n_tests++;
        if (n_done != 0 || late != 0) begin
            n_fail++; $display("FAIL midreset_quiet got %0d done %0d active cycles want 0 0", n_done, late);
        end
        run_frame(0, 1'b0, 0);
        analyze();
        check_frame("after_reset");
    endtask

    task automatic test_back_to_back();
        int diff;
        fill_random();
        run_frame(0, 1'b0, 0);
        analyze();
        check_frame("b2b_first");
        for (int i = 0; i < 16; i++) saved[i] = (i < n_vld) ? rec_dat[vidx[i]] : '0;
        run_frame(0, 1'b0, 0);
        analyze();
        check_frame("b2b_second");
        diff = 0;
        for (int i = 0; i < 16; i++)
            if (i >= n_vld || rec_dat[vidx[i]] !== saved[i]) diff++;
        n_tests++;
        if (diff != 0) begin n_fail++; $display("FAIL b2b_identical got %0d differing windows want 0", diff); end
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 3; n++) begin
            fill_random();
            run_frame(0, 1'b0, 0);
            analyze();
            check_frame("random");
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_corner();
        test_left_edge();
        test_invalid_data();
        test_start_filter();
        test_reset_mid_frame();
        test_back_to_back();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
